dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter: CPU_PRIORITY, default 0, 1 = CPU port always wins, 0 = round-robin between ports.
REQ-002 SHALL have port: clk  in  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port: reset  in  1  reset, synchronous, active-low (asserted when 0).
REQ-004 SHALL have ports: cpu_req, dma_req  in  1 each  access request, held high until the matching done.
REQ-005 SHALL have ports: cpu_we, dma_we  in  1 each  1 = store, 0 = load.
REQ-006 SHALL have ports: cpu_xfer_size, dma_xfer_size  in  4 each  bytes to transfer.
REQ-007 SHALL have ports: cpu_addr, dma_addr, cpu_wdata, dma_wdata  in  64 each  address and store data.
REQ-008 SHALL have ports: cpu_done, dma_done  out  1 each  one-cycle completion pulse.
REQ-009 SHALL have ports: cpu_err, dma_err  out  1 each  valid with done; access rejected.
REQ-010 SHALL have ports: cpu_rdata, dma_rdata  out  64 each  load data, valid with done.
REQ-011 SHALL have port: cpu_stall  out  1  pipeline stall = cpu_req AND NOT cpu_done (combinational).
REQ-012 SHALL have ports: mem_address, mem_write_data  out  64 each; mem_xfer_size  out  4; mem_write_enable, mem_read_enable  out  1 each  drive the data memory.
REQ-013 SHALL have port: mem_read_data  in  64  data memory read data, valid combinationally during the read cycle.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-015 SHALL arbitrate only in IDLE; requests arriving in ACCESS or DONE wait.
REQ-016 SHALL, in IDLE with one request high, grant that port at the next edge.
REQ-017 SHALL, with both requests high and CPU_PRIORITY=1, grant CPU.
REQ-018 SHALL, with both requests high and CPU_PRIORITY=0, grant the port not granted last; last-grant register resets to "DMA" so CPU wins first.
REQ-019 SHALL latch the granted port's we, xfer_size, addr and wdata at the grant edge; later input changes are ignored until DONE.
REQ-020 SHALL treat xfer_size not in {1,2,4,8}, or addr not a multiple of xfer_size, as an error: go IDLE->DONE directly, no memory enable asserted.
REQ-021 SHALL, for a legal request, go IDLE->ACCESS->DONE; in ACCESS drive mem_* from the latched payload, mem_write_enable = we, mem_read_enable = NOT we, for exactly one cycle.
REQ-022 SHALL capture mem_read_data into a 64-bit rdata register at the end of ACCESS for loads; stores and errors load 0.
REQ-023 SHALL, in DONE, pulse done (and err if applicable) for the granted port only, with rdata on that port's rdata; the other port's done/err stay 0; then go IDLE.
REQ-024 SHALL hold mem_write_enable and mem_read_enable 0 outside ACCESS; mem_address, mem_write_data and mem_xfer_size hold the latched payload at all times.
REQ-025 SHALL achieve latency: request high in cycle N (IDLE) -> done high in cycle N+2 (legal) or N+1 (error).
REQ-026 SHALL rely on requester deasserting req after sampling done; req still high in the IDLE after DONE is a new request.
REQ-027 SHALL update last-grant at each grant edge, including error grants.
REQ-028 SHALL keep cpu_rdata/dma_rdata as the last captured value for that port between dones.

Reset
REQ-029 SHALL, on a reset edge: state IDLE, all done/err 0, mem enables 0, latched payload and rdata 0, last-grant DMA.
REQ-030 SHALL, on reset mid-ACCESS or mid-DONE, abandon the transaction without a done pulse; a store already driven in ACCESS before that edge is allowed to complete.
REQ-031 SHALL ignore requests while reset is asserted.

Verification
REQ-032 SHALL: CPU store addr=128, wdata=69, size 8, then CPU load addr=128 -> mem_write_enable one cycle, cpu_done at N+2, load cpu_rdata=69, cpu_err=0.
REQ-033 SHALL: both ports request simultaneously, CPU_PRIORITY=0, held for 4 transactions -> grants alternate CPU, DMA, CPU, DMA.
REQ-034 SHALL: same with CPU_PRIORITY=1 -> CPU granted every time, dma_done never pulses while cpu_req stays high.
REQ-035 SHALL: CPU load addr=130, size 4 -> cpu_done and cpu_err at N+1, rdata 0, no memory enable asserted; size 3 same.
REQ-036 SHALL: reset asserted during ACCESS of a DMA load -> no dma_done, state IDLE, enables 0 next cycle, next CPU request served normally.
REQ-037 SHALL: cpu_req high -> cpu_stall high every cycle until cpu_done cycle, low in that cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port (CPU/DMA) data-memory arbiter with alignment check,
//                single-cycle memory access and one-cycle done/err pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int CPU_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_xfer_size,
    input  logic [63:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [63:0] cpu_rdata,
    output logic        cpu_stall,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [3:0]  dma_xfer_size,
    input  logic [63:0] dma_addr,
    input  logic [63:0] dma_wdata,
    output logic        dma_done,
    output logic        dma_err,
    output logic [63:0] dma_rdata,

    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    output logic [3:0]  mem_xfer_size,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    input  logic [63:0] mem_read_data
);

    localparam logic c_cpu_wins = (CPU_PRIORITY != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_grant_dma;
    logic        r_last_dma;
    logic        r_we;
    logic [3:0]  r_size;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic        r_mem_we;
    logic        r_mem_re;
    logic        r_cpu_done;
    logic        r_cpu_err;
    logic        r_dma_done;
    logic        r_dma_err;
    logic [63:0] r_cpu_rdata;
    logic [63:0] r_dma_rdata;

    logic        w_any_req;
    logic        w_pick_dma;
    logic        w_sel_we;
    logic [3:0]  w_sel_size;
    logic [63:0] w_sel_addr;
    logic [63:0] w_sel_wdata;
    logic        w_size_ok;
    logic        w_aligned;
    logic        w_legal;

    // With both requesting: fixed CPU priority, or whichever port lost last time.
    assign w_any_req  = cpu_req | dma_req;
    assign w_pick_dma = dma_req & (~cpu_req | (~c_cpu_wins & ~r_last_dma));

    assign w_sel_we    = w_pick_dma ? dma_we        : cpu_we;
    assign w_sel_size  = w_pick_dma ? dma_xfer_size : cpu_xfer_size;
    assign w_sel_addr  = w_pick_dma ? dma_addr      : cpu_addr;
    assign w_sel_wdata = w_pick_dma ? dma_wdata     : cpu_wdata;

    assign w_size_ok = (w_sel_size == 4'd1) || (w_sel_size == 4'd2) ||
                       (w_sel_size == 4'd4) || (w_sel_size == 4'd8);
    // Only meaningful when the size is a legal power of two.
    assign w_aligned = ((w_sel_addr[3:0] & (w_sel_size - 4'd1)) == 4'd0);
    assign w_legal   = w_size_ok & w_aligned;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_grant_dma <= 1'b0;
            r_last_dma  <= 1'b1;
            r_we        <= 1'b0;
            r_size      <= 4'd0;
            r_addr      <= 64'd0;
            r_wdata     <= 64'd0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_dma_done  <= 1'b0;
            r_dma_err   <= 1'b0;
            r_cpu_rdata <= 64'd0;
            r_dma_rdata <= 64'd0;
        end else begin
            r_mem_we   <= 1'b0;
            r_mem_re   <= 1'b0;
            r_cpu_done <= 1'b0;
            r_cpu_err  <= 1'b0;
            r_dma_done <= 1'b0;
            r_dma_err  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant_dma <= w_pick_dma;
                        r_last_dma  <= w_pick_dma;
                        r_we        <= w_sel_we;
                        r_size      <= w_sel_size;
                        r_addr      <= w_sel_addr;
                        r_wdata     <= w_sel_wdata;
                        if (w_legal) begin
                            r_state  <= ST_ACCESS;
                            r_mem_we <= w_sel_we;
                            r_mem_re <= ~w_sel_we;
                        end else begin
                            // Rejected access skips memory and reports at once.
                            r_state <= ST_DONE;
                            if (w_pick_dma) begin
                                r_dma_done  <= 1'b1;
                                r_dma_err   <= 1'b1;
                                r_dma_rdata <= 64'd0;
                            end else begin
                                r_cpu_done  <= 1'b1;
                                r_cpu_err   <= 1'b1;
                                r_cpu_rdata <= 64'd0;
                            end
                        end
                    end
                end

                ST_ACCESS: begin
                    r_state <= ST_DONE;
                    if (r_grant_dma) begin
                        r_dma_done  <= 1'b1;
                        r_dma_rdata <= r_we ? 64'd0 : mem_read_data;
                    end else begin
                        r_cpu_done  <= 1'b1;
                        r_cpu_rdata <= r_we ? 64'd0 : mem_read_data;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_done  = r_cpu_done;
    assign cpu_err   = r_cpu_err;
    assign cpu_rdata = r_cpu_rdata;
    assign cpu_stall = cpu_req & ~r_cpu_done;

    assign dma_done  = r_dma_done;
    assign dma_err   = r_dma_err;
    assign dma_rdata = r_dma_rdata;

    assign mem_address      = r_addr;
    assign mem_write_data   = r_wdata;
    assign mem_xfer_size    = r_size;
    assign mem_write_enable = r_mem_we;
    assign mem_read_enable  = r_mem_re;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter (both modes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [3:0]  cpu_xfer_size, dma_xfer_size;
    logic [63:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

    logic        cpu_done, cpu_err, cpu_stall, dma_done, dma_err;
    logic [63:0] cpu_rdata, dma_rdata, mem_address, mem_write_data, mem_read_data;
    logic [3:0]  mem_xfer_size;
    logic        mem_write_enable, mem_read_enable;

    logic        cpu_req1, dma_req1;
    logic        cpu_done1, cpu_err1, cpu_stall1, dma_done1, dma_err1;
    logic [63:0] cpu_rdata1, dma_rdata1, mem_address1, mem_write_data1;
    logic [3:0]  mem_xfer_size1;
    logic        mem_write_enable1, mem_read_enable1;
    logic [63:0] mem_read_data1;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] c_dma_word = 64'hDEAD_BEEF_0123_4567;

    always #5 clk = ~clk;

    dmem_arbiter #(.CPU_PRIORITY(0)) u_dut_rr (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_xfer_size(cpu_xfer_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_xfer_size(dma_xfer_size),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_done(dma_done), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_xfer_size(mem_xfer_size), .mem_write_enable(mem_write_enable),
        .mem_read_enable(mem_read_enable), .mem_read_data(mem_read_data)
    );

    dmem_arbiter #(.CPU_PRIORITY(1)) u_dut_prio (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req1), .cpu_we(cpu_we), .cpu_xfer_size(cpu_xfer_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done1), .cpu_err(cpu_err1), .cpu_rdata(cpu_rdata1), .cpu_stall(cpu_stall1),
        .dma_req(dma_req1), .dma_we(dma_we), .dma_xfer_size(dma_xfer_size),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_done(dma_done1), .dma_err(dma_err1), .dma_rdata(dma_rdata1),
        .mem_address(mem_address1), .mem_write_data(mem_write_data1),
        .mem_xfer_size(mem_xfer_size1), .mem_write_enable(mem_write_enable1),
        .mem_read_enable(mem_read_enable1), .mem_read_data(mem_read_data1)
    );

    // Word-addressed memory model; word 1 is preloaded for the DMA loads.
    logic [63:0] mem [0:63];
    bit          mem_loaded;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 64'd0;
            mem[1]     <= c_dma_word;
            mem_loaded <= 1'b1;
        end else if (mem_write_enable) begin
            mem[mem_address[8:3]] <= mem_write_data;
        end
    end
    assign mem_read_data  = mem[mem_address[8:3]];
    assign mem_read_data1 = 64'd0;

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (cpu_done !== 1'b0) begin errors++; $display("FAIL reset_cpu_done got %0b want 0", cpu_done); end
        checks++; if (dma_done !== 1'b0 || dma_err !== 1'b0 || cpu_err !== 1'b0) begin errors++; $display("FAIL reset_dma_done_err got %0b%0b%0b want 000", dma_done, dma_err, cpu_err); end
        checks++; if ({mem_write_enable, mem_read_enable} !== 2'b00) begin errors++; $display("FAIL reset_mem_en got %b want 00", {mem_write_enable, mem_read_enable}); end
        checks++; if (mem_address !== 64'd0 || mem_write_data !== 64'd0 || mem_xfer_size !== 4'd0) begin errors++; $display("FAIL reset_payload got %h/%h/%h want 0", mem_address, mem_write_data, mem_xfer_size); end
        checks++; if (cpu_rdata !== 64'd0 || dma_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0", cpu_rdata, dma_rdata); end
        checks++; if (cpu_stall !== 1'b0 || cpu_stall1 !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b/%0b want 0", cpu_stall, cpu_stall1); end
        checks++; if ({cpu_done1, cpu_err1, dma_done1, dma_err1, mem_write_enable1, mem_read_enable1} !== 6'd0) begin errors++; $display("FAIL reset_prio_flags got %b want 000000", {cpu_done1, cpu_err1, dma_done1, dma_err1, mem_write_enable1, mem_read_enable1}); end
        checks++; if ((cpu_rdata1 | dma_rdata1 | mem_address1 | mem_write_data1) !== 64'd0 || mem_xfer_size1 !== 4'd0) begin errors++; $display("FAIL reset_prio_data got nonzero want 0"); end
        reset = 1'b1;
    endtask

    task automatic test_store_load;
        @(negedge clk);
        cpu_we = 1'b1; cpu_xfer_size = 4'd8; cpu_addr = 64'd128; cpu_wdata = 64'd69; cpu_req = 1'b1;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL st_stall_n got %0b want 1", cpu_stall); end
        @(negedge clk);
        checks++; if ({mem_write_enable, mem_read_enable} !== 2'b10) begin errors++; $display("FAIL st_access_en got %b want 10", {mem_write_enable, mem_read_enable}); end
        checks++; if (mem_address !== 64'd128 || mem_write_data !== 64'd69 || mem_xfer_size !== 4'd8) begin errors++; $display("FAIL st_payload got %0d/%0d/%0d want 128/69/8", mem_address, mem_write_data, mem_xfer_size); end
        checks++; if (cpu_done !== 1'b0 || cpu_stall !== 1'b1) begin errors++; $display("FAIL st_n1 done/stall got %0b/%0b want 0/1", cpu_done, cpu_stall); end
        cpu_wdata = 64'd0;
        @(negedge clk);
        checks++; if (cpu_done !== 1'b1 || cpu_err !== 1'b0 || dma_done !== 1'b0) begin errors++; $display("FAIL st_done got %0b/%0b/%0b want 1/0/0", cpu_done, cpu_err, dma_done); end
        checks++; if (cpu_stall !== 1'b0 || mem_write_enable !== 1'b0) begin errors++; $display("FAIL st_done stall/we got %0b/%0b want 0/0", cpu_stall, mem_write_enable); end
        checks++; if (mem_write_data !== 64'd69) begin errors++; $display("FAIL st_latch got %0d want 69", mem_write_data); end
        cpu_req = 1'b0;
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = 64'd128; cpu_req = 1'b1;
        @(negedge clk);
        checks++; if ({mem_write_enable, mem_read_enable} !== 2'b01) begin errors++; $display("FAIL ld_access_en got %b want 01", {mem_write_enable, mem_read_enable}); end
        cpu_addr = 64'd0;
        @(negedge clk);
        checks++; if (cpu_done !== 1'b1 || cpu_err !== 1'b0) begin errors++; $display("FAIL ld_done got %0b/%0b want 1/0", cpu_done, cpu_err); end
        checks++; if (cpu_rdata !== 64'd69) begin errors++; $display("FAIL ld_rdata got %0d want 69", cpu_rdata); end
        checks++; if (mem_address !== 64'd128) begin errors++; $display("FAIL ld_latch got %0d want 128", mem_address); end
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_done !== 1'b0 || cpu_rdata !== 64'd69) begin errors++; $display("FAIL ld_hold done/rdata got %0b/%0d want 0/69", cpu_done, cpu_rdata); end
    endtask

    task automatic test_misaligned;
        logic [3:0]  sizes [2] = '{4'd4, 4'd3};
        logic [63:0] addrs [2] = '{64'd130, 64'd128};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cpu_we = 1'b0; cpu_xfer_size = sizes[k]; cpu_addr = addrs[k]; cpu_req = 1'b1;
            @(negedge clk);
            checks++; if (cpu_done !== 1'b1 || cpu_err !== 1'b1) begin errors++; $display("FAIL err%0d done/err got %0b/%0b want 1/1", k, cpu_done, cpu_err); end
            checks++; if (cpu_rdata !== 64'd0) begin errors++; $display("FAIL err%0d rdata got %h want 0", k, cpu_rdata); end
            checks++; if ({mem_write_enable, mem_read_enable} !== 2'b00) begin errors++; $display("FAIL err%0d mem_en got %b want 00", k, {mem_write_enable, mem_read_enable}); end
            cpu_req = 1'b0;
            @(negedge clk);
            checks++; if (cpu_done !== 1'b0 || mem_read_enable !== 1'b0) begin errors++; $display("FAIL err%0d after got %0b/%0b want 0/0", k, cpu_done, mem_read_enable); end
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_dma = 4'b1010;
        logic       rearm_cpu = 1'b0;
        logic       rearm_dma = 1'b0;
        int         n = 0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        cpu_we = 1'b0; cpu_xfer_size = 4'd8; cpu_addr = 64'd128;
        dma_we = 1'b0; dma_xfer_size = 4'd8; dma_addr = 64'd8;
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(negedge clk);
            if (rearm_cpu) begin cpu_req = 1'b1; rearm_cpu = 1'b0; end
            if (rearm_dma) begin dma_req = 1'b1; rearm_dma = 1'b0; end
            if (cpu_done || dma_done) begin
                checks++; if ({dma_done, cpu_done} !== (exp_dma[n] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant%0d got %b want %b", n, {dma_done, cpu_done}, exp_dma[n] ? 2'b10 : 2'b01); end
                if (cpu_done) begin
                    checks++; if (cpu_rdata !== 64'd69) begin errors++; $display("FAIL rr_cpu_rdata%0d got %h want 45", n, cpu_rdata); end
                    cpu_req = 1'b0; rearm_cpu = 1'b1;
                end
                if (dma_done) begin
                    checks++; if (dma_rdata !== c_dma_word) begin errors++; $display("FAIL rr_dma_rdata%0d got %h want %h", n, dma_rdata, c_dma_word); end
                    dma_req = 1'b0; rearm_dma = 1'b1;
                end
                n++;
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL rr_timeout got %0d dones want 4", n); end
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cpu_priority;
        logic rearm = 1'b0;
        logic dma_seen = 1'b0;
        int   n = 0;
        @(negedge clk);
        cpu_we = 1'b0; cpu_xfer_size = 4'd8; cpu_addr = 64'd128;
        dma_we = 1'b0; dma_xfer_size = 4'd8; dma_addr = 64'd8;
        cpu_req1 = 1'b1; dma_req1 = 1'b1;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(negedge clk);
            if (rearm) begin cpu_req1 = 1'b1; rearm = 1'b0; end
            checks++; if (dma_done1 !== 1'b0) begin errors++; $display("FAIL prio_dma_done cyc%0d got %0b want 0", cyc, dma_done1); end
            if (cpu_done1) begin n++; cpu_req1 = 1'b0; rearm = 1'b1; end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL prio_cpu_count got %0d want 4", n); end
        cpu_req1 = 1'b0;
        for (int cyc = 0; cyc < 10 && !dma_seen; cyc++) begin
            @(negedge clk);
            if (dma_done1) begin dma_seen = 1'b1; dma_req1 = 1'b0; end
        end
        checks++; if (dma_seen !== 1'b1) begin errors++; $display("FAIL prio_dma_served got %0b want 1", dma_seen); end
        dma_req1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk);
        dma_we = 1'b0; dma_xfer_size = 4'd8; dma_addr = 64'd8; dma_req = 1'b1;
        @(negedge clk);
        checks++; if (mem_read_enable !== 1'b1) begin errors++; $display("FAIL rst_mid_access got %0b want 1", mem_read_enable); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (dma_done !== 1'b0 || mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin errors++; $display("FAIL rst_mid_after got %0b/%0b/%0b want 0/0/0", dma_done, mem_read_enable, mem_write_enable); end
        checks++; if (mem_address !== 64'd0 || cpu_rdata !== 64'd0) begin errors++; $display("FAIL rst_mid_clear got %h/%h want 0/0", mem_address, cpu_rdata); end
        reset = 1'b1; dma_req = 1'b0;
        @(negedge clk);
        checks++; if (dma_done !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done got %0b want 0", dma_done); end
        cpu_we = 1'b0; cpu_xfer_size = 4'd8; cpu_addr = 64'd128; cpu_req = 1'b1;
        @(negedge clk);
        checks++; if (mem_read_enable !== 1'b1 || dma_done !== 1'b0) begin errors++; $display("FAIL rst_next_access got %0b/%0b want 1/0", mem_read_enable, dma_done); end
        @(negedge clk);
        checks++; if (cpu_done !== 1'b1 || cpu_rdata !== 64'd69) begin errors++; $display("FAIL rst_next_done got %0b/%0d want 1/69", cpu_done, cpu_rdata); end
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_xfer_size = 4'd0; cpu_addr = 64'd0; cpu_wdata = 64'd0;
        dma_req = 1'b0; dma_we = 1'b0; dma_xfer_size = 4'd0; dma_addr = 64'd0; dma_wdata = 64'd0;
        cpu_req1 = 1'b0; dma_req1 = 1'b0;
        test_reset;
        test_store_load;
        test_misaligned;
        test_round_robin;
        test_cpu_priority;
        test_reset_mid_access;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
